// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: fires one-hot irq pulses after LFSR-random or fixed
// delays while the core sequencer is idle, with a watchdog and sticky end-of-run flag.
module irq_stim_gen #(
  parameter int          NUM_IRQ       = 4,
  parameter int          DELAY_WIDTH   = 3,
  parameter int          TIMEOUT_WIDTH = 12,
  parameter int          PULSE_LEN     = 1,
  parameter int          MODE          = 0,
  parameter int          FIX_DELAY     = 2,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     ps_idle,
  input  logic [NUM_IRQ-1:0]       irq_ack,
  input  logic                     finish_op,
  input  logic                     stck_ovf,
  output logic [NUM_IRQ-1:0]       irq,
  output logic                     done,
  output logic [1:0]               done_code,
  output logic [TIMEOUT_WIDTH-1:0] tmo_cnt
);

  localparam int          CW   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int          PW   = $clog2(PULSE_LEN + 1);
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {ARM, WAIT, FIRE} state_t;

  state_t                 state;
  logic [DELAY_WIDTH-1:0] cnt;
  logic [CW-1:0]          chan;
  logic [CW-1:0]          rr_ptr;
  logic [PW-1:0]          pulse_cnt;
  logic [15:0]            lfsr;

  logic [15:0]            lfsr_next;
  logic [DELAY_WIDTH-1:0] delay_sample;
  logic [CW-1:0]          chan_sample;
  logic [CW-1:0]          rr_next;
  logic                   run;
  logic                   tmo_full;
  logic                   stop_req;
  logic                   done_next;
  logic                   ack_hit;
  logic [1:0]             code_next;

  // Next-value samples; ack_hit works because irq is one-hot on chan while in FIRE
  always_comb begin
    lfsr_next    = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    delay_sample = (MODE == 1) ? DELAY_WIDTH'(FIX_DELAY) : lfsr[DELAY_WIDTH-1:0];
    rr_next      = (NUM_IRQ == 1) ? '0 : rr_ptr + CW'(1);
    if (MODE == 1)
      chan_sample = rr_ptr;
    else if (NUM_IRQ == 1)
      chan_sample = '0;
    else
      chan_sample = lfsr[DELAY_WIDTH +: CW];
    run       = enable & ~done;
    tmo_full  = &tmo_cnt;
    stop_req  = finish_op | stck_ovf | tmo_full;
    done_next = done | stop_req;
    ack_hit   = |(irq_ack & irq);
    if (finish_op)
      code_next = 2'b01;
    else if (stck_ovf)
      code_next = 2'b10;
    else if (tmo_full)
      code_next = 2'b11;
    else
      code_next = 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARM;
      irq       <= '0;
      cnt       <= '0;
      chan      <= '0;
      rr_ptr    <= '0;
      pulse_cnt <= '0;
      lfsr      <= SEED;
      tmo_cnt   <= '0;
      done      <= 1'b0;
      done_code <= 2'b00;
    end else begin
      if (run) begin
        lfsr <= lfsr_next;
        if (!tmo_full)
          tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
      end
      if (!done && stop_req) begin
        done      <= 1'b1;
        done_code <= code_next;
      end
      // Ending the run parks the FSM and drops irq on the same edge done sets
      if (done_next) begin
        state <= ARM;
        irq   <= '0;
      end else if (enable) begin
        case (state)
          ARM: begin
            if (ps_idle) begin
              cnt  <= delay_sample;
              chan <= chan_sample;
              if (MODE == 1)
                rr_ptr <= rr_next;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (ps_idle) begin
              if (cnt == '0) begin
                state     <= FIRE;
                irq       <= NUM_IRQ'(1) << chan;
                pulse_cnt <= PW'(1);
              end else begin
                cnt <= cnt - DELAY_WIDTH'(1);
              end
            end
          end
          FIRE: begin
            if (ack_hit || pulse_cnt == PW'(PULSE_LEN)) begin
              state <= ARM;
              irq   <= '0;
            end else begin
              pulse_cnt <= pulse_cnt + PW'(1);
            end
          end
          default: begin
            state <= ARM;
            irq   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_stim_gen.sv
// Bench for irq_stim_gen: four instances (LFSR mode, round-robin PULSE_LEN 1 and 4,
// short watchdog) driven from vector tables through an expected-result queue.
module tb_irq_stim_gen;

  typedef struct {
    int          unit;
    int          row;
    logic        en;
    logic        idle;
    logic        fin;
    logic        ovf;
    logic [3:0]  ack;
    logic [3:0]  irq;
    logic        dn;
    logic [1:0]  code;
    logic [11:0] tmo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  en_r = '0;
  logic [3:0]  idle_r = '0;
  logic [3:0]  fin_r = '0;
  logic [3:0]  ovf_r = '0;
  logic [3:0]  ack_r [4];
  logic [3:0]  irq_w [4];
  logic        done_w [4];
  logic [1:0]  code_w [4];
  logic [11:0] tmo_w [3];
  logic [3:0]  tmo_c;

  int   n_assert = 0;
  int   n_fail = 0;
  vec_t sb [$];
  vec_t tbl0 [$];
  vec_t tbl_a [$];
  vec_t tbl_b [$];

  always #5 clk = ~clk;

  irq_stim_gen u0 (
    .clk(clk), .reset(reset), .enable(en_r[0]), .ps_idle(idle_r[0]), .irq_ack(ack_r[0]),
    .finish_op(fin_r[0]), .stck_ovf(ovf_r[0]), .irq(irq_w[0]), .done(done_w[0]),
    .done_code(code_w[0]), .tmo_cnt(tmo_w[0]));

  irq_stim_gen #(.MODE(1), .FIX_DELAY(2), .PULSE_LEN(1)) u1 (
    .clk(clk), .reset(reset), .enable(en_r[1]), .ps_idle(idle_r[1]), .irq_ack(ack_r[1]),
    .finish_op(fin_r[1]), .stck_ovf(ovf_r[1]), .irq(irq_w[1]), .done(done_w[1]),
    .done_code(code_w[1]), .tmo_cnt(tmo_w[1]));

  irq_stim_gen #(.MODE(1), .FIX_DELAY(2), .PULSE_LEN(4)) u2 (
    .clk(clk), .reset(reset), .enable(en_r[2]), .ps_idle(idle_r[2]), .irq_ack(ack_r[2]),
    .finish_op(fin_r[2]), .stck_ovf(ovf_r[2]), .irq(irq_w[2]), .done(done_w[2]),
    .done_code(code_w[2]), .tmo_cnt(tmo_w[2]));

  irq_stim_gen #(.TIMEOUT_WIDTH(4)) u3 (
    .clk(clk), .reset(reset), .enable(en_r[3]), .ps_idle(idle_r[3]), .irq_ack(ack_r[3]),
    .finish_op(fin_r[3]), .stck_ovf(ovf_r[3]), .irq(irq_w[3]), .done(done_w[3]),
    .done_code(code_w[3]), .tmo_cnt(tmo_c));

  function automatic logic [11:0] get_tmo(int u);
    if (u == 3)
      return {8'h00, tmo_c};
    return tmo_w[u];
  endfunction

  function automatic vec_t mk(int unit, int row, logic en, logic idle, logic fin, logic ovf,
                              logic [3:0] ack, logic [3:0] irq, logic dn, logic [1:0] code,
                              logic [11:0] tmo);
    vec_t v;
    v.unit = unit; v.row = row; v.en = en; v.idle = idle; v.fin = fin; v.ovf = ovf;
    v.ack = ack; v.irq = irq; v.dn = dn; v.code = code; v.tmo = tmo;
    return v;
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check($sformatf("u%0d_r%0d_irq", e.unit, e.row), {8'h00, irq_w[e.unit]}, {8'h00, e.irq});
    check($sformatf("u%0d_r%0d_done", e.unit, e.row), {11'h000, done_w[e.unit]}, {11'h000, e.dn});
    check($sformatf("u%0d_r%0d_code", e.unit, e.row), {10'h000, code_w[e.unit]}, {10'h000, e.code});
    check($sformatf("u%0d_r%0d_tmo", e.unit, e.row), get_tmo(e.unit), e.tmo);
  endtask

  task automatic applyStimulus(input vec_t v);
    en_r = '0; idle_r = '0; fin_r = '0; ovf_r = '0;
    for (int k = 0; k < 4; k++) ack_r[k] = '0;
    en_r[v.unit]   = v.en;
    idle_r[v.unit] = v.idle;
    fin_r[v.unit]  = v.fin;
    ovf_r[v.unit]  = v.ovf;
    ack_r[v.unit]  = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_r = '0; idle_r = '0; fin_r = '0; ovf_r = '0;
    for (int k = 0; k < 4; k++) ack_r[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst_u%0d_irq", u), {8'h00, irq_w[u]}, 12'h000);
      check($sformatf("rst_u%0d_done", u), {11'h000, done_w[u]}, 12'h000);
      check($sformatf("rst_u%0d_code", u), {10'h000, code_w[u]}, 12'h000);
      check($sformatf("rst_u%0d_tmo", u), get_tmo(u), 12'h000);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] irq_e;
    for (int k = 0; k < 4; k++) ack_r[k] = '0;

    // LFSR mode from SEED ACE1: delay 1 ch0, then delay 6 ch1, then delay 6 ch2
    for (int i = 0; i < 22; i++) begin
      irq_e = (i == 2) ? 4'b0001 : (i == 11) ? 4'b0010 : (i == 20) ? 4'b0100 : 4'b0000;
      tbl0.push_back(mk(0, i, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, irq_e, 1'b0, 2'b00, 12'(i + 1)));
    end

    // Round robin, delay 2: one pulse every 5 edges, then a 5-cycle idle stall, then finish+ovf
    for (int i = 0; i < 46; i++) begin
      if (i < 25)
        irq_e = (i % 5 == 3) ? (4'b0001 << (((i + 1) / 5) % 4)) : 4'b0000;
      else
        irq_e = (i == 33) ? 4'b0010 : (i == 38) ? 4'b0100 : 4'b0000;
      tbl_a.push_back(mk(1, i, 1'b1, !(i >= 27 && i <= 31), i == 40, i == 40, 4'h0, irq_e,
                         i >= 40, (i >= 40) ? 2'b01 : 2'b00, (i >= 40) ? 12'd41 : 12'(i + 1)));
    end

    // PULSE_LEN 4: full hold, ack on matching channel in cycle 2, ack on wrong channel
    for (int i = 0; i < 22; i++) begin
      logic [3:0] ack_e;
      ack_e = (i == 13) ? 4'b0010 : (i >= 17 && i <= 20) ? 4'b0001 : 4'b0000;
      irq_e = (i >= 3 && i <= 6) ? 4'b0001 : (i == 11 || i == 12) ? 4'b0010 :
              (i >= 17 && i <= 20) ? 4'b0100 : 4'b0000;
      tbl_b.push_back(mk(2, i, 1'b1, 1'b1, 1'b0, 1'b0, ack_e, irq_e, 1'b0, 2'b00, 12'(i + 1)));
    end

    do_reset();
    foreach (tbl0[i]) applyStimulus(tbl0[i]);

    // Reset asserted mid-FIRE clears irq without a clock edge; sequence then restarts from SEED
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(tbl0[i]);
    #1 reset = 1'b1;
    #1;
    check("async_rst_irq", {8'h00, irq_w[0]}, 12'h000);
    check("async_rst_tmo", tmo_w[0], 12'h000);
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (tbl0[i]) applyStimulus(tbl0[i]);

    do_reset();
    foreach (tbl_a[i]) applyStimulus(tbl_a[i]);

    do_reset();
    foreach (tbl_b[i]) applyStimulus(tbl_b[i]);

    // Watchdog of 4 bits saturates at 15 and ends the run one edge later with code 11
    do_reset();
    for (int i = 0; i < 18; i++)
      applyStimulus(mk(3, i, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, i >= 15,
                       (i >= 15) ? 2'b11 : 2'b00, (i + 1 > 15) ? 12'd15 : 12'(i + 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
